power_emulator_mc: RTL and testbench

Multi-channel, programmable-weight power emulator with a 32-bit memory-mapped slave port. Each cycle it samples NCH clock-gate-enable inputs and sums a per-channel energy weight for every active enable. The sums are accumulated over a programmable window, and the block reports window energy, peak instantaneous power and a threshold interrupt. It is the next-generation replacement for the fixed-weight single-window emulator IP and sits on the same register bus.

---
 rtl/power_emu_pkg.sv | 41 ++++
 rtl/weighted_sum_tree.sv | 56 +++++
 rtl/power_emulator_mc.sv | 236 +++++++++++++++++++++++
 tb/tb_power_emulator_mc.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/power_emu_pkg.sv
// Shared definitions for the multi-channel power emulator.
// Holds the register word addresses, CTRL/STATUS bit positions and the
// width helpers used to size the instantaneous sum and the accumulator.
package power_emu_pkg;

    // Register word addresses
    localparam logic [3:0] AddrCtrl   = 4'd0;
    localparam logic [3:0] AddrStatus = 4'd1;
    localparam logic [3:0] AddrWindow = 4'd2;
    localparam logic [3:0] AddrWidx   = 4'd3;
    localparam logic [3:0] AddrWdata  = 4'd4;
    localparam logic [3:0] AddrResLo  = 4'd5;
    localparam logic [3:0] AddrResHi  = 4'd6;
    localparam logic [3:0] AddrPeak   = 4'd7;
    localparam logic [3:0] AddrThresh = 4'd8;
    localparam logic [3:0] AddrWcount = 4'd9;

    // CTRL bit positions
    localparam int unsigned CtrlRun   = 0;
    localparam int unsigned CtrlClr   = 1;
    localparam int unsigned CtrlIrqEn = 2;
    localparam int unsigned CtrlCont  = 3;

    // STATUS bit positions
    localparam int unsigned StatDone    = 0;
    localparam int unsigned StatBusy    = 1;
    localparam int unsigned StatOver    = 2;
    localparam int unsigned StatOverrun = 3;

    // Width of one cycle's weighted sum: BITS plus log2(NCH) growth bits.
    function automatic int unsigned sum_width(input int unsigned nch, input int unsigned bits);
        return bits + $clog2(nch);
    endfunction

    // Accumulator width: a full window of maximum sums never overflows.
    function automatic int unsigned acc_width(input int unsigned nch, input int unsigned bits,
                                              input int unsigned cntw);
        return sum_width(nch, bits) + cntw;
    endfunction

endpackage

// File: rtl/weighted_sum_tree.sv
// Masked weight reduction for the power emulator (pipeline stage 2).
// Each weight is gated by its registered enable, the gated values are reduced
// by a balanced binary adder tree, and the result is registered as o_inst.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_cges       : stage-1 registered enables (NCH)
//   i_weights    : per-channel weights (NCH x BITS)
//   o_inst       : registered instantaneous sum (BITS + clog2(NCH))
module weighted_sum_tree
    import power_emu_pkg::*;
#(
    parameter int unsigned NCH  = 12,
    parameter int unsigned BITS = 24
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NCH-1:0]                        i_cges,
    input  logic [NCH-1:0][BITS-1:0]              i_weights,
    output logic [sum_width(NCH, BITS)-1:0]       o_inst
);

    localparam int unsigned SW     = sum_width(NCH, BITS);
    localparam int unsigned Levels = $clog2(NCH);
    localparam int unsigned NumPad = 1 << Levels;

    // w_lvl[l][j] holds node j of tree level l; level 0 is the masked leaves,
    // padded with zeros up to a power of two.
    logic [SW-1:0] w_lvl [0:Levels][0:NumPad-1];
    logic [SW-1:0] r_inst;

    always_comb begin
        for (int unsigned l = 0; l <= Levels; l++) begin
            for (int unsigned j = 0; j < NumPad; j++) begin
                w_lvl[l][j] = '0;
            end
        end
        for (int unsigned j = 0; j < NCH; j++) begin
            w_lvl[0][j] = i_cges[j] ? SW'(i_weights[j]) : '0;
        end
        for (int unsigned l = 1; l <= Levels; l++) begin
            for (int unsigned j = 0; j < (NumPad >> l); j++) begin
                w_lvl[l][j] = w_lvl[l-1][2*j] + w_lvl[l-1][2*j+1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inst <= '0;
        end else begin
            r_inst <= w_lvl[Levels][0];
        end
    end

    assign o_inst = r_inst;

endmodule

// File: rtl/power_emulator_mc.sv
// Multi-channel programmable-weight power emulator with a 32-bit register port.
// Samples NCH clock-gate enables each running cycle, sums per-channel weights,
// accumulates over a programmable window and reports window energy, peak
// instantaneous power and a threshold/completion interrupt.
//   clk, reset_n          : clock, asynchronous active-low reset
//   cges                  : per-channel enable samples
//   s_read, s_write       : register strobes
//   s_addr, s_wdata       : word address, write data
//   s_rdata               : registered read data (valid cycle after s_read)
//   irq                   : level interrupt
module power_emulator_mc
    import power_emu_pkg::*;
#(
    parameter int unsigned NCH  = 12,
    parameter int unsigned BITS = 24,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NCH-1:0]  cges,
    input  logic            s_read,
    input  logic            s_write,
    input  logic [3:0]      s_addr,
    input  logic [31:0]     s_wdata,
    output logic [31:0]     s_rdata,
    output logic            irq
);

    localparam int unsigned SW   = sum_width(NCH, BITS);
    localparam int unsigned ACCW = acc_width(NCH, BITS, CNTW);

    // Control / configuration
    logic                      r_run;
    logic                      r_irq_en;
    logic                      r_cont;
    logic [CNTW-1:0]           r_window;
    logic [3:0]                r_widx;
    logic [NCH-1:0][BITS-1:0]  r_weight;
    logic [31:0]               r_thresh;

    // Results / status
    logic [ACCW-1:0]           r_res;
    logic [SW-1:0]             r_peak;
    logic [31:0]               r_wcount;
    logic                      r_done;
    logic                      r_over;
    logic                      r_overrun;

    // Datapath
    logic [CNTW-1:0]           r_scnt;
    logic [NCH-1:0]            r_cges_s1;
    logic                      r_v1;
    logic                      r_last1;
    logic                      r_v2;
    logic                      r_last2;
    logic [ACCW-1:0]           r_acc;
    logic [31:0]               r_rdata;

    logic [SW-1:0]             w_inst;
    logic [CNTW-1:0]           w_win_eff;
    logic                      w_last_sample;
    logic                      w_wr_ctrl;
    logic                      w_wr_status;
    logic                      w_clr;
    logic                      w_end;
    logic [ACCW-1:0]           w_acc_sum;
    logic [63:0]               w_res64;
    logic [BITS-1:0]           w_weight_rd;
    logic [31:0]               w_rdata;

    // ---------------------------------------------------------------------
    // Write decode
    // ---------------------------------------------------------------------
    assign w_wr_ctrl   = s_write && (s_addr == AddrCtrl);
    assign w_wr_status = s_write && (s_addr == AddrStatus);
    assign w_clr       = w_wr_ctrl && s_wdata[CtrlClr];

    // ---------------------------------------------------------------------
    // Sample issue: windows are counted as samples enter stage 1 so that an
    // auto-stop after the last sample lets no extra sample into the pipeline.
    // ---------------------------------------------------------------------
    assign w_win_eff     = (r_window == '0) ? CNTW'(1) : r_window;
    // >= rather than == so a WINDOW shrunk mid-window still terminates.
    assign w_last_sample = r_run && (r_scnt >= (w_win_eff - CNTW'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run     <= 1'b0;
            r_irq_en  <= 1'b0;
            r_cont    <= 1'b0;
            r_window  <= '0;
            r_widx    <= '0;
            r_thresh  <= '0;
            r_weight  <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_run    <= s_wdata[CtrlRun];
                r_irq_en <= s_wdata[CtrlIrqEn];
                r_cont   <= s_wdata[CtrlCont];
            end else if (w_last_sample && !r_cont) begin
                r_run    <= 1'b0;
            end
            if (s_write && (s_addr == AddrWindow)) r_window <= s_wdata[CNTW-1:0];
            if (s_write && (s_addr == AddrWidx))   r_widx   <= s_wdata[3:0];
            if (s_write && (s_addr == AddrThresh)) r_thresh <= s_wdata;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (s_write && (s_addr == AddrWdata) && (r_widx == 4'(i))) begin
                    r_weight[i] <= s_wdata[BITS-1:0];
                end
            end
        end
    end

    // Stage 1 and valid/last tags for stage 2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cges_s1 <= '0;
            r_scnt    <= '0;
            r_v1      <= 1'b0;
            r_last1   <= 1'b0;
            r_v2      <= 1'b0;
            r_last2   <= 1'b0;
        end else begin
            r_cges_s1 <= cges;
            if (w_clr) begin
                r_scnt  <= '0;
                r_v1    <= 1'b0;
                r_last1 <= 1'b0;
                r_v2    <= 1'b0;
                r_last2 <= 1'b0;
            end else begin
                if (r_run) r_scnt <= w_last_sample ? '0 : r_scnt + CNTW'(1);
                r_v1    <= r_run;
                r_last1 <= w_last_sample;
                r_v2    <= r_v1;
                r_last2 <= r_last1;
            end
        end
    end

    weighted_sum_tree #(
        .NCH  (NCH),
        .BITS (BITS)
    ) u_sum_tree (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_cges    (r_cges_s1),
        .i_weights (r_weight),
        .o_inst    (w_inst)
    );

    // ---------------------------------------------------------------------
    // Stage 3: accumulate, peak, threshold, window close
    // ---------------------------------------------------------------------
    assign w_acc_sum = r_acc + ACCW'(w_inst);
    // clr suppresses a same-cycle window end entirely.
    assign w_end     = r_v2 && r_last2 && !w_clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc     <= '0;
            r_res     <= '0;
            r_peak    <= '0;
            r_wcount  <= '0;
            r_done    <= 1'b0;
            r_over    <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_clr) begin
            r_acc     <= '0;
            r_peak    <= '0;
            r_wcount  <= '0;
            r_done    <= 1'b0;
            r_over    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_v2) r_acc <= w_end ? '0 : w_acc_sum;
            if (w_end) begin
                r_res    <= w_acc_sum;
                r_wcount <= r_wcount + 32'd1;
            end
            if (r_v2 && (w_inst > r_peak)) r_peak <= w_inst;

            // Hardware set has priority over a same-cycle W1C.
            if (w_end)                                   r_done <= 1'b1;
            else if (w_wr_status && s_wdata[StatDone])   r_done <= 1'b0;

            if (w_end && r_done)                         r_overrun <= 1'b1;
            else if (w_wr_status && s_wdata[StatOverrun]) r_overrun <= 1'b0;

            if (r_v2 && (32'(w_inst) > r_thresh))        r_over <= 1'b1;
            else if (w_wr_status && s_wdata[StatOver])   r_over <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Read path
    // ---------------------------------------------------------------------
    assign w_res64 = 64'(r_res);

    always_comb begin
        w_weight_rd = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (r_widx == 4'(i)) w_weight_rd = r_weight[i];
        end
    end

    always_comb begin
        w_rdata = '0;
        case (s_addr)
            AddrCtrl:   w_rdata = {28'd0, r_cont, r_irq_en, 1'b0, r_run};
            AddrStatus: w_rdata = {28'd0, r_overrun, r_over, r_run, r_done};
            AddrWindow: w_rdata = 32'(r_window);
            AddrWidx:   w_rdata = {28'd0, r_widx};
            AddrWdata:  w_rdata = 32'(w_weight_rd);
            AddrResLo:  w_rdata = w_res64[31:0];
            AddrResHi:  w_rdata = w_res64[63:32];
            AddrPeak:   w_rdata = 32'(r_peak);
            AddrThresh: w_rdata = r_thresh;
            AddrWcount: w_rdata = r_wcount;
            default:    w_rdata = '0;
        endcase
    end

    // Sampled at the same edge as any write, so a simultaneous read sees pre-write state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (s_read) begin
            r_rdata <= w_rdata;
        end
    end

    assign s_rdata = r_rdata;
    assign irq     = r_irq_en & (r_done | r_over | r_overrun);

endmodule

// File: tb/tb_power_emulator_mc.sv
// Directed self-checking bench for power_emulator_mc (NCH=12, BITS=24, CNTW=16).
module tb_power_emulator_mc;

    logic        clk;
    logic        reset_n;
    logic [11:0] cges;
    logic        s_read;
    logic        s_write;
    logic [3:0]  s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic        irq;

    int unsigned n_checks;
    int unsigned n_fails;

    power_emulator_mc #(
        .NCH  (12),
        .BITS (24),
        .CNTW (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cges    (cges),
        .s_read  (s_read),
        .s_write (s_write),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        s_write = 1'b1;
        s_addr  = a;
        s_wdata = d;
        @(negedge clk);
        s_write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        s_read = 1'b1;
        s_addr = a;
        @(negedge clk);
        s_read = 1'b0;
        d = s_rdata;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check_eq(tag, 64'(d), 64'(exp));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset_n  = 1'b0;
        cges     = '0;
        s_read   = 1'b0;
        s_write  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        idle(2);
        check_eq("reset_irq", 64'(irq), 64'd0);
        check_eq("reset_rdata", 64'(s_rdata), 64'd0);
        reset_n = 1'b1;
        idle(1);

        // Reset values of every register plus an unmapped address
        for (int a = 0; a < 10; a++) read_check($sformatf("reset_reg%0d", a), 4'(a), 32'd0);
        read_check("unmapped_12", 4'd12, 32'd0);

        // Weights w[i] = i+1
        for (int i = 0; i < 12; i++) begin
            bus_write(4'd3, 32'(i));
            bus_write(4'd4, 32'(i + 1));
        end
        bus_write(4'd3, 32'd5);
        read_check("weight5", 4'd4, 32'd6);
        bus_write(4'd3, 32'd12);
        bus_write(4'd4, 32'h55);
        read_check("weight_idx12", 4'd4, 32'd0);
        bus_write(4'd3, 32'd0);
        read_check("weight0", 4'd4, 32'd1);

        // Single window, cont=0
        bus_write(4'd8, 32'd1000);
        bus_write(4'd2, 32'd4);
        cges = 12'hFFF;
        bus_write(4'd0, 32'h1);
        idle(10);
        read_check("w1_res_lo", 4'd5, 32'd312);
        read_check("w1_res_hi", 4'd6, 32'd0);
        read_check("w1_status", 4'd1, 32'h1);
        read_check("w1_ctrl", 4'd0, 32'h0);
        read_check("w1_wcount", 4'd9, 32'd1);
        read_check("w1_peak", 4'd7, 32'd78);

        // Three continuous windows with done left set
        bus_write(4'd0, 32'h2);
        read_check("clr_status", 4'd1, 32'h0);
        read_check("clr_res_kept", 4'd5, 32'd312);
        read_check("clr_peak", 4'd7, 32'd0);
        bus_write(4'd0, 32'h9);
        idle(11);
        bus_write(4'd0, 32'h0);
        idle(5);
        read_check("cont_wcount", 4'd9, 32'd3);
        read_check("cont_status", 4'd1, 32'h9);
        read_check("cont_res", 4'd5, 32'd312);
        check_eq("cont_irq_dis", 64'(irq), 64'd0);
        bus_write(4'd0, 32'h4);
        check_eq("cont_irq_en", 64'(irq), 64'd1);
        bus_write(4'd1, 32'h9);
        read_check("w1c_status", 4'd1, 32'h0);
        check_eq("w1c_irq", 64'(irq), 64'd0);

        // Threshold: first a low window, then alternating sums
        bus_write(4'd0, 32'h2);
        bus_write(4'd8, 32'd50);
        cges = 12'h00F;
        bus_write(4'd0, 32'h1);
        idle(8);
        read_check("lo_status", 4'd1, 32'h1);
        read_check("lo_peak", 4'd7, 32'd10);
        read_check("lo_res", 4'd5, 32'd40);
        bus_write(4'd0, 32'h1);
        cges = 12'hFFF; @(negedge clk);
        cges = 12'h00F; @(negedge clk);
        cges = 12'hFFF; @(negedge clk);
        cges = 12'h00F; @(negedge clk);
        idle(5);
        read_check("alt_status", 4'd1, 32'hD);
        read_check("alt_peak", 4'd7, 32'd78);
        read_check("alt_res", 4'd5, 32'd176);

        // Pause mid-window
        bus_write(4'd0, 32'h2);
        bus_write(4'd8, 32'd1000);
        cges = 12'hFFF;
        bus_write(4'd0, 32'h1);
        bus_write(4'd0, 32'h0);
        idle(5);
        read_check("pause_status", 4'd1, 32'h0);
        read_check("pause_wcount", 4'd9, 32'd0);
        bus_write(4'd0, 32'h1);
        idle(8);
        read_check("resume_res", 4'd5, 32'd312);
        read_check("resume_wcount", 4'd9, 32'd1);
        read_check("resume_status", 4'd1, 32'h1);

        // clr lands on the window-end edge
        bus_write(4'd0, 32'h2);
        cges = 12'h00F;
        bus_write(4'd0, 32'h1);
        idle(5);
        bus_write(4'd0, 32'h2);
        idle(3);
        read_check("clrend_res", 4'd5, 32'd312);
        read_check("clrend_status", 4'd1, 32'h0);
        read_check("clrend_wcount", 4'd9, 32'd0);

        // Asynchronous reset while running
        bus_write(4'd8, 32'd5);
        bus_write(4'd0, 32'hD);
        idle(6);
        check_eq("pre_rst_irq", 64'(irq), 64'd1);
        read_check("pre_rst_window", 4'd2, 32'd4);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_eq("async_rst_irq", 64'(irq), 64'd0);
        check_eq("async_rst_rdata", 64'(s_rdata), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);
        for (int a = 0; a < 10; a++) read_check($sformatf("post_rst_reg%0d", a), 4'(a), 32'd0);
        check_eq("post_rst_irq", 64'(irq), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
